// File: rtl/if_id_buffer.sv
// Fetch-to-decode decoupling ring FIFO carrying {PC, instruction} with flush and drop counting.
// Latency: one cycle from fetch push to id_valid_o; no same-cycle pass-through.
// Backpressure: fetch_ready_o drops when full (holds the PC) and depends only on registered occupancy.
module if_id_buffer #(
   parameter int unsigned DEPTH     = 2,
   parameter int unsigned PTR_W     = 1,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             fetch_valid_i,
   input  logic [31:0]      fetch_pc_i,
   input  logic [31:0]      fetch_instr_i,
   output logic             fetch_ready_o,
   output logic             id_valid_o,
   output logic [31:0]      id_pc_o,
   output logic [31:0]      id_pc_plus4_o,
   output logic [31:0]      id_instr_o,
   input  logic             id_ready_i,
   output logic [PTR_W:0]   count_o,
   output logic [15:0]      drop_cnt_o
);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   entry_t           mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic [15:0]      drop_cnt_q, drop_cnt_d;
   logic [16:0]      drop_sum;
   logic             push, pop;
   entry_t           head;

   // Handshakes are derived from registered occupancy only, so fetch_ready_o
   // has no combinational path from decode or flush.
   assign fetch_ready_o = (count_q < FULL_CNT);
   assign id_valid_o    = (count_q != '0);
   assign push          = fetch_valid_i & fetch_ready_o;
   assign pop           = id_valid_o & id_ready_i;

   // Show-ahead head; an empty buffer presents PC 0 and a NOP to decode.
   assign head          = mem_q[rd_ptr_q];
   assign id_pc_o       = id_valid_o ? head.pc : 32'd0;
   assign id_instr_o    = id_valid_o ? head.instr : NOP_INSTR;
   assign id_pc_plus4_o = id_pc_o + 32'd4;
   assign count_o       = count_q;
   assign drop_cnt_o    = drop_cnt_q;

   // Drop counter accumulates the pre-flush occupancy, clamped at all-ones.
   assign drop_sum = {1'b0, drop_cnt_q} + 17'(count_q);

   // Next-state: flush overrides any same-cycle push or pop.
   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      drop_cnt_d = drop_cnt_q;
      if (flush_i) begin
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Control state with asynchronous active-low clear.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         drop_cnt_q <= '0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Storage array is not reset; only occupancy decides what is visible.
   always_ff @(posedge clk_i) begin
      if (push && !flush_i) begin
         mem_q[wr_ptr_q] <= '{pc: fetch_pc_i, instr: fetch_instr_i};
      end
   end

endmodule

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
- Decoupling buffer between the fetch stage (program counter plus instruction memory) and the decode stage of the pipelined CPU.
- Captures each fetched instruction with its PC in a small ring FIFO and presents it to decode with a valid/ready handshake.
- Generates the fetch-side ready that drives the PC hold (PCWrite) control.
- Supports branch/jump flush and keeps a saturating count of instructions discarded by flushes.

Parameters:
- DEPTH, 2, number of FIFO entries; power of two, minimum 2.
- PTR_W, 1, pointer width; equals log2(DEPTH).
- NOP_INSTR, 32'h0000_0000, instruction word driven to decode when the buffer is empty.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset; asynchronous, active-low.
- flush_i  input  1  synchronous flush request from branch/jump resolution.
- fetch_valid_i  input  1  fetch presents a valid instruction this cycle.
- fetch_pc_i  input  32  PC of the presented instruction.
- fetch_instr_i  input  32  instruction word from instruction memory.
- fetch_ready_o  output  1  buffer accepts a push this cycle; low = hold PC.
- id_valid_o  output  1  head entry valid for decode.
- id_pc_o  output  32  PC of head entry.
- id_pc_plus4_o  output  32  head PC + 4.
- id_instr_o  output  32  instruction word of head entry.
- id_ready_i  input  1  decode consumes head this cycle.
- count_o  output  PTR_W+1  current occupancy, 0..DEPTH.
- drop_cnt_o  output  16  saturating count of entries discarded by flush.

Behaviour:
- Reset (rst_i=0, asynchronous): read pointer, write pointer, count and drop_cnt all 0.
  - Outputs during and after reset: id_valid_o=0, id_pc_o=0, id_pc_plus4_o=4, id_instr_o=NOP_INSTR, fetch_ready_o=1.
  - Storage array contents are not reset.
- Push = fetch_valid_i & fetch_ready_o. Writes {fetch_pc_i, fetch_instr_i} at the write pointer; write pointer increments modulo DEPTH.
- Pop = id_valid_o & id_ready_i. Read pointer increments modulo DEPTH.
- fetch_ready_o = (count < DEPTH). It is a function of registered state only; no combinational path from id_ready_i or flush_i.
- id_valid_o = (count != 0).
- Head outputs are show-ahead from the read pointer. When empty: id_pc_o=0, id_instr_o=NOP_INSTR.
- id_pc_plus4_o = id_pc_o + 32'd4, mod 2^32 (0xFFFF_FFFC -> 0x0000_0000).
- Latency: a push into an empty buffer appears on id_valid_o at the next edge. There is no same-cycle pass-through.
- Count update on each edge:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push and pop together.
  - Push and pop together are legal at any count with 0 < count < DEPTH.
- When full, fetch_ready_o=0, so a pop in that cycle frees one slot for the following cycle only.
- Flush (flush_i=1 at the edge) has highest priority:
  - Pointers and count go to 0.
  - Any same-cycle push and pop are ignored. The decode-side pop does not count as consumed.
  - drop_cnt += count (value before the flush), saturating at 16'hFFFF.
  - id_valid_o is 0 in the cycle after the flush.
- Flush while empty: drop_cnt unchanged.
- Reset asserted mid-operation: all state cleared immediately, including drop_cnt.
- No overflow or underflow is possible: pushes are gated by fetch_ready_o and pops by id_valid_o.

Test Plan:
- Reset, then push PC=0x0000_0040, instr=0x2008_0005 with id_ready_i=0 -> next cycle id_valid_o=1, id_pc_o=0x40, id_pc_plus4_o=0x44, count_o=1, fetch_ready_o=1.
- Push 2 instructions with id_ready_i=0 (DEPTH=2) -> count_o=2, fetch_ready_o=0. A third fetch_valid_i is not accepted. Set id_ready_i=1 -> first PC pops, fetch_ready_o returns to 1 the next cycle, order is preserved.
- Continuous push and pop for 10 cycles, PCs 0x0,0x4,...,0x24 -> id_pc_o follows the same sequence one cycle behind, count_o stays 1, pointers wrap with no loss.
- Fill to 2, then assert flush_i together with fetch_valid_i=1 and id_ready_i=1 -> next cycle count_o=0, id_valid_o=0, id_instr_o=NOP_INSTR, drop_cnt_o=2.
- Preload drop_cnt to 0xFFFE via repeated flushes, then flush with count=2 -> drop_cnt_o=0xFFFF and stays there.
- Push PC=0xFFFF_FFFC -> id_pc_plus4_o=0x0000_0000. Assert rst_i=0 mid-cycle with count=1 -> id_valid_o=0 immediately, without waiting for a clock edge.
